// File: rtl/my_cpu.sv
`default_nettype none
// ============================================================================
// Module      : my_cpu (with my_cpu_regfile, my_cpu_wordmem, my_cpu_imem)
// Description : Single-cycle 32-bit MIPS-subset core. Every rising clock edge
//               retires one instruction: the PC, the register file and the
//               data memory all update together. All memories are internal
//               and are preloaded through hierarchical paths.
// Ports       : clk - sole clock, all state updates on the rising edge
//               rst - synchronous active-high reset, forces PC to 0 and
//                     blocks register-file and data-memory writes
// Revision    : 1.0 - initial release
// ============================================================================

// 32 x 32 register file: two combinational read ports, one write port.
// Register 0 is an ordinary storage location and is not hardwired to zero.
module my_cpu_regfile (
    input  logic        clk,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);
    logic [31:0] rf [0:31];

    // A same-cycle read of the register being written returns the old value.
    assign o_rd1 = rf[i_ra1];
    assign o_rd2 = rf[i_ra2];

    always_ff @(posedge clk) begin
        if (i_we) begin
            rf[i_wa] <= i_wd;
        end
    end
endmodule

// 1024-word memory: combinational read, write on the rising edge.
module my_cpu_wordmem (
    input  logic        clk,
    input  logic        i_we,
    input  logic [9:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] mm [0:1023];

    assign o_rdata = mm[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mm[i_addr] <= i_wdata;
        end
    end
endmodule

// Instruction memory: a word memory whose write port is never used by the
// core; contents are loaded from outside through u_im.mem.mm.
module my_cpu_imem (
    input  logic        clk,
    input  logic [9:0]  i_addr,
    output logic [31:0] o_instr
);
    my_cpu_wordmem mem (
        .clk     (clk),
        .i_we    (1'b0),
        .i_addr  (i_addr),
        .i_wdata (32'd0),
        .o_rdata (o_instr)
    );
endmodule

module my_cpu (
    input  logic clk,
    input  logic rst
);
    // Opcodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    // R-type function codes
    localparam logic [5:0] c_fn_sll   = 6'b000000;
    localparam logic [5:0] c_fn_srl   = 6'b000010;
    localparam logic [5:0] c_fn_sra   = 6'b000011;
    localparam logic [5:0] c_fn_jr    = 6'b001000;
    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_xor   = 6'b100110;
    localparam logic [5:0] c_fn_nor   = 6'b100111;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_sltu  = 6'b101011;

    logic [31:0] r_pc;
    logic [31:0] w_instr;
    logic [31:0] w_pc_plus4;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [31:0] w_sext, w_zext;
    logic [31:0] w_a, w_b;
    logic [31:0] w_addr;
    logic [31:0] w_dm_rdata;
    logic        w_rf_we, w_dm_we;
    logic [4:0]  w_rf_wa;
    logic [31:0] w_rf_wd;
    logic [31:0] w_pc_next;
    logic        w_unused_addr;

    my_cpu_imem u_im (
        .clk     (clk),
        .i_addr  (r_pc[11:2]),
        .o_instr (w_instr)
    );

    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_shamt = w_instr[10:6];
    assign w_funct = w_instr[5:0];
    assign w_sext  = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_zext  = {16'd0, w_instr[15:0]};

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_addr     = w_a + w_sext;
    // Memory accesses wrap modulo 4 KB; the remaining address bits are dropped.
    assign w_unused_addr = &{1'b0, w_addr[31:12], w_addr[1:0]};

    // Writes are suppressed while reset is held so a reset edge never
    // commits a partially fetched instruction.
    my_cpu_regfile u_regfile (
        .clk   (clk),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_a),
        .o_rd2 (w_b),
        .i_we  (w_rf_we & ~rst),
        .i_wa  (w_rf_wa),
        .i_wd  (w_rf_wd)
    );

    my_cpu_wordmem dm (
        .clk     (clk),
        .i_we    (w_dm_we & ~rst),
        .i_addr  (w_addr[11:2]),
        .i_wdata (w_b),
        .o_rdata (w_dm_rdata)
    );

    // Decode / execute. Anything not recognised falls through the defaults
    // and behaves as a nop.
    always_comb begin
        w_rf_we   = 1'b0;
        w_rf_wa   = w_rt;
        w_rf_wd   = 32'd0;
        w_dm_we   = 1'b0;
        w_pc_next = w_pc_plus4;
        case (w_op)
            c_op_rtype: begin
                w_rf_we = 1'b1;
                w_rf_wa = w_rd;
                case (w_funct)
                    c_fn_add, c_fn_addu: w_rf_wd = w_a + w_b;
                    c_fn_sub, c_fn_subu: w_rf_wd = w_a - w_b;
                    c_fn_and:  w_rf_wd = w_a & w_b;
                    c_fn_or:   w_rf_wd = w_a | w_b;
                    c_fn_xor:  w_rf_wd = w_a ^ w_b;
                    c_fn_nor:  w_rf_wd = ~(w_a | w_b);
                    c_fn_slt:  w_rf_wd = {31'd0, $signed(w_a) < $signed(w_b)};
                    c_fn_sltu: w_rf_wd = {31'd0, w_a < w_b};
                    c_fn_sll:  w_rf_wd = w_b << w_shamt;
                    c_fn_srl:  w_rf_wd = w_b >> w_shamt;
                    c_fn_sra:  w_rf_wd = $unsigned($signed(w_b) >>> w_shamt);
                    c_fn_jr: begin
                        w_rf_we   = 1'b0;
                        w_pc_next = w_a;
                    end
                    default:   w_rf_we = 1'b0;
                endcase
            end
            c_op_addi, c_op_addiu: begin
                w_rf_we = 1'b1;
                w_rf_wd = w_a + w_sext;
            end
            c_op_slti: begin
                w_rf_we = 1'b1;
                w_rf_wd = {31'd0, $signed(w_a) < $signed(w_sext)};
            end
            c_op_andi: begin
                w_rf_we = 1'b1;
                w_rf_wd = w_a & w_zext;
            end
            c_op_ori: begin
                w_rf_we = 1'b1;
                w_rf_wd = w_a | w_zext;
            end
            c_op_xori: begin
                w_rf_we = 1'b1;
                w_rf_wd = w_a ^ w_zext;
            end
            c_op_lui: begin
                w_rf_we = 1'b1;
                w_rf_wd = {w_instr[15:0], 16'd0};
            end
            c_op_lw: begin
                w_rf_we = 1'b1;
                w_rf_wd = w_dm_rdata;
            end
            c_op_sw: begin
                w_dm_we = 1'b1;
            end
            // Branch offset is a byte offset from the branch itself.
            c_op_beq: begin
                if (w_a == w_b) begin
                    w_pc_next = r_pc + w_sext;
                end
            end
            c_op_bne: begin
                if (w_a != w_b) begin
                    w_pc_next = r_pc + w_sext;
                end
            end
            c_op_j: begin
                w_pc_next = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
            end
            c_op_jal: begin
                w_pc_next = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
                w_rf_we   = 1'b1;
                w_rf_wa   = 5'd31;
                w_rf_wd   = w_pc_plus4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_my_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_cpu
// Description : Directed bench for my_cpu. Expected architectural state is
//               queued as each cycle is driven and checked after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    my_cpu dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0: PC, 1: register, 2: data memory word
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [4:0] sh, logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] target);
        return {op, target};
    endfunction

    task automatic exp_push(input string tag, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Advance one edge, then drain the scoreboard against the new state.
    task automatic step();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = dut.r_pc;
                1:       obs = dut.u_regfile.rf[e.idx];
                default: obs = dut.dm.mm[e.idx];
            endcase
            n_vec++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clear_im();
        for (int i = 0; i < 128; i++) dut.u_im.mem.mm[i] = 32'd0;
    endtask

    task automatic clear_rf();
        for (int i = 0; i < 32; i++) dut.u_regfile.rf[i] = 32'd0;
    endtask

    initial begin
        // ---------------- program 1 ----------------
        clear_im();
        clear_rf();
        for (int i = 0; i < 8; i++) dut.dm.mm[i] = i;
        dut.u_im.mem.mm[0]  = enc_i(6'b001001, 5'd0, 5'd1, 16'd2);           // addiu r1,r0,2
        dut.u_im.mem.mm[1]  = enc_i(6'b001111, 5'd0, 5'd0, 16'd3);           // lui r0,3
        dut.u_im.mem.mm[2]  = enc_r(5'd0, 5'd1, 5'd2, 5'd0, 6'b100000);      // add r2,r0,r1
        dut.u_im.mem.mm[3]  = enc_i(6'b101011, 5'd1, 5'd2, 16'd6);           // sw r2,6(r1)
        dut.u_im.mem.mm[4]  = enc_i(6'b100011, 5'd1, 5'd3, 16'd2);           // lw r3,2(r1)
        dut.u_im.mem.mm[5]  = enc_r(5'd0, 5'd0, 5'd4, 5'd2, 6'b000011);      // sra r4,r0,2
        dut.u_im.mem.mm[6]  = enc_i(6'b000100, 5'd0, 5'd1, 16'd20);          // beq r0,r1,20
        dut.u_im.mem.mm[7]  = enc_i(6'b000100, 5'd10, 5'd11, 16'd16);        // beq r10,r11,16
        dut.u_im.mem.mm[8]  = enc_i(6'b001001, 5'd0, 5'd9, 16'h0123);        // skipped
        dut.u_im.mem.mm[9]  = enc_i(6'b001001, 5'd0, 5'd9, 16'h0124);        // skipped
        dut.u_im.mem.mm[10] = enc_i(6'b001001, 5'd0, 5'd9, 16'h0125);        // skipped
        dut.u_im.mem.mm[11] = enc_j(6'b000010, 26'd0);                       // j 0

        rst = 1'b1;
        exp_push("reset_pc", 0, 0, 32'h0);
        exp_push("reset_no_rf_write", 1, 1, 32'h0);
        step();
        rst = 1'b0;

        exp_push("addiu_pc", 0, 0, 32'h4);  exp_push("addiu_r1", 1, 1, 32'h2);          step();
        exp_push("lui_pc", 0, 0, 32'h8);    exp_push("lui_r0", 1, 0, 32'h0003_0000);    step();
        exp_push("add_pc", 0, 0, 32'hC);    exp_push("add_r2", 1, 2, 32'h0003_0002);    step();
        exp_push("sw_pc", 0, 0, 32'h10);    exp_push("sw_dm2", 2, 2, 32'h0003_0002);    step();
        exp_push("lw_pc", 0, 0, 32'h14);    exp_push("lw_r3", 1, 3, 32'h1);             step();
        exp_push("sra_pc", 0, 0, 32'h18);   exp_push("sra_r4", 1, 4, 32'h0000_C000);    step();
        exp_push("beq_not_taken_pc", 0, 0, 32'h1C);                                     step();
        exp_push("beq_taken_pc", 0, 0, 32'h2C);                                         step();
        exp_push("j0_pc", 0, 0, 32'h0);     exp_push("skipped_r9", 1, 9, 32'h0);        step();
        exp_push("loop2_pc", 0, 0, 32'h4);  exp_push("loop2_r1", 1, 1, 32'h0003_0002);  step();
        exp_push("loop2_lui_pc", 0, 0, 32'h8); exp_push("loop2_r0", 1, 0, 32'h0003_0000); step();

        // Reset lands on the add at 0x08: it must not commit.
        rst = 1'b1;
        exp_push("midrst_pc", 0, 0, 32'h0);
        exp_push("midrst_r2_kept", 1, 2, 32'h0003_0002);
        exp_push("midrst_dm2_kept", 2, 2, 32'h0003_0002);
        step();
        rst = 1'b0;
        exp_push("restart_pc", 0, 0, 32'h4); exp_push("restart_r1", 1, 1, 32'h0003_0002); step();

        // ---------------- program 2 ----------------
        rst = 1'b1;
        clear_im();
        clear_rf();
        dut.u_regfile.rf[8] = 32'd100;
        dut.u_regfile.rf[9] = 32'h0000_DEAD;
        dut.u_im.mem.mm[0]  = enc_i(6'b001001, 5'd0, 5'd5, 16'hFFFF);        // addiu r5,r0,-1
        dut.u_im.mem.mm[1]  = enc_i(6'b001001, 5'd0, 5'd6, 16'd1);           // addiu r6,r0,1
        dut.u_im.mem.mm[2]  = enc_r(5'd5, 5'd6, 5'd7, 5'd0, 6'b101010);      // slt r7,r5,r6
        dut.u_im.mem.mm[3]  = enc_r(5'd5, 5'd6, 5'd9, 5'd0, 6'b101011);      // sltu r9,r5,r6
        dut.u_im.mem.mm[4]  = enc_i(6'b001001, 5'd8, 5'd12, 16'hFFFF);       // addiu r12,r8,-1
        dut.u_im.mem.mm[5]  = enc_i(6'b001101, 5'd8, 5'd13, 16'h8000);       // ori r13,r8,0x8000
        dut.u_im.mem.mm[6]  = enc_r(5'd0, 5'd5, 5'd14, 5'd28, 6'b000010);    // srl r14,r5,28
        dut.u_im.mem.mm[7]  = enc_r(5'd0, 5'd6, 5'd15, 5'd31, 6'b000000);    // sll r15,r6,31
        dut.u_im.mem.mm[8]  = enc_r(5'd6, 5'd0, 5'd16, 5'd0, 6'b100111);     // nor r16,r6,r0
        dut.u_im.mem.mm[9]  = enc_r(5'd6, 5'd5, 5'd17, 5'd0, 6'b100011);     // subu r17,r6,r5
        dut.u_im.mem.mm[10] = enc_i(6'b001110, 5'd5, 5'd18, 16'h00FF);       // xori r18,r5,0xFF
        dut.u_im.mem.mm[11] = enc_i(6'b001100, 5'd5, 5'd19, 16'h8001);       // andi r19,r5,0x8001
        dut.u_im.mem.mm[12] = enc_i(6'b001010, 5'd5, 5'd20, 16'd1);          // slti r20,r5,1
        dut.u_im.mem.mm[13] = enc_i(6'b000101, 5'd6, 5'd0, 16'd8);           // bne r6,r0,8
        dut.u_im.mem.mm[14] = enc_i(6'b001001, 5'd0, 5'd21, 16'h0077);       // skipped
        dut.u_im.mem.mm[15] = enc_j(6'b000011, 26'h14);                      // jal 0x50
        dut.u_im.mem.mm[16] = enc_i(6'b111111, 5'd0, 5'd22, 16'h0055);       // undefined op
        dut.u_im.mem.mm[17] = enc_i(6'b001001, 5'd0, 5'd24, 16'd5);          // addiu r24,r0,5
        dut.u_im.mem.mm[18] = enc_j(6'b000010, 26'h12);                      // j 0x48 (halt)
        dut.u_im.mem.mm[19] = enc_i(6'b001001, 5'd0, 5'd22, 16'h0099);       // skipped
        dut.u_im.mem.mm[20] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000);     // jr r31

        exp_push("p2_reset_pc", 0, 0, 32'h0);
        exp_push("p2_reset_no_write", 1, 5, 32'h0);
        step();
        rst = 1'b0;

        exp_push("addiu_m1_r5", 1, 5, 32'hFFFF_FFFF);                        step();
        exp_push("addiu_r6", 1, 6, 32'h1);                                   step();
        exp_push("slt_r7", 1, 7, 32'h1);                                     step();
        exp_push("sltu_r9", 1, 9, 32'h0);                                    step();
        exp_push("addiu_dec_r12", 1, 12, 32'd99);                            step();
        exp_push("ori_r13", 1, 13, 32'h0000_8064);                           step();
        exp_push("srl_r14", 1, 14, 32'h0000_000F);                           step();
        exp_push("sll_r15", 1, 15, 32'h8000_0000);                           step();
        exp_push("nor_r16", 1, 16, 32'hFFFF_FFFE);                           step();
        exp_push("subu_r17", 1, 17, 32'h2);                                  step();
        exp_push("xori_r18", 1, 18, 32'hFFFF_FF00);                          step();
        exp_push("andi_r19", 1, 19, 32'h0000_8001);                          step();
        exp_push("slti_pc", 0, 0, 32'h34);  exp_push("slti_r20", 1, 20, 32'h1); step();
        exp_push("bne_taken_pc", 0, 0, 32'h3C);                              step();
        exp_push("jal_pc", 0, 0, 32'h50);   exp_push("jal_r31", 1, 31, 32'h40); step();
        exp_push("jr_pc", 0, 0, 32'h40);    exp_push("bne_skip_r21", 1, 21, 32'h0); step();
        exp_push("undef_pc", 0, 0, 32'h44); exp_push("undef_r22", 1, 22, 32'h0); step();
        exp_push("addiu_r24", 1, 24, 32'd5); exp_push("addiu_r24_pc", 0, 0, 32'h48); step();
        exp_push("halt_pc", 0, 0, 32'h48);                                   step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/my_cpu.md
# my_cpu

Single-cycle 32-bit MIPS-subset processor core with internal instruction memory, data memory and a 32-entry register file. Each rising clock edge retires exactly one instruction: PC, register file and data memory update together. It is the top-level compute block; no external memory or I/O ports. Benches preload memories and registers through hierarchical paths.

## Interface
- No parameters. Fixed sizes: IM 1024 words, DM 1024 words, register file 32 x 32 bits.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high; forces PC to 0.
- Hierarchy, fixed for bench access:
  - Register file instance u_regfile, array rf[0:31].
  - Instruction memory instance u_im containing instance mem with word array mm[0:1023].
  - Data memory instance dm with word array mm[0:1023].

## Operation
- Fetch: instr = u_im.mem.mm[PC[11:2]]. PC is a byte address.
- Fields:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
  - sext = sign-extended imm; zext = zero-extended imm.
- R-type (op=0), result written to rd:
  - add(100000) and addu(100001): rs+rt. No overflow trap.
  - sub(100010) and subu(100011): rs-rt.
  - and(100100), or(100101), xor(100110), nor(100111).
  - slt(101010) signed compare; sltu(101011) unsigned compare.
  - sll(000000) rt<<shamt; srl(000010) rt>>shamt logical; sra(000011) rt>>>shamt arithmetic.
  - jr(001000): PC<=rs; no register write.
- I-type, result written to rt:
  - addi(001000) and addiu(001001): rs+sext.
  - slti(001010): rs<sext, signed.
  - andi(001100), ori(001101), xori(001110): logical op with zext.
  - lui(001111): {imm,16'b0}.
  - lw(100011): rt<=dm.mm[(rs+sext)[11:2]].
  - sw(101011): dm.mm[(rs+sext)[11:2]]<=rt.
- Branches and jumps:
  - beq(000100): taken if rs==rt. bne(000101): taken if rs!=rt.
  - Taken target = PC_of_branch + sext. The offset is a byte offset: no shift and no +4.
  - Not taken: PC<=PC+4.
  - j(000010): PC<={PC+4[31:28], imm26, 2'b00}.
  - jal(000011): same target as j; r31<=PC+4.
- Register 0 is an ordinary writable register; it is not hardwired to zero.
- Writes to rd or rt of register 0 take effect.
- Undefined opcode or funct: treated as a nop (PC+4, no writes).
- Address bits above [11:2] and low bits [1:0] are ignored; memory accesses wrap modulo 4 KB.

## Timing
- Register file: two combinational read ports, one write port written on the rising edge.
- Data memory: combinational read, write on the rising edge.
- Instruction memory: combinational read.
- Reset:
  - A rising edge with rst=1 sets PC=0.
  - While rst=1, no register-file or DM write occurs.
  - Register-file and memory contents are not cleared by reset.
- After rst deasserts, the instruction at address 0 executes in the first cycle. Its results are visible after the next rising edge.
- Latency: one cycle per instruction. No stalls, no delay slots, no forwarding hazards.
- Read-after-write: an instruction reads register values committed at the preceding edge.
- Same-cycle read and write of one register: the read returns the old value.

## Test plan
- Program setup:
  - Initialise rf=0 and dm.mm[i]=i for i=0..7.
  - Load the program below, pulse rst for one edge, then run.
- addiu r1,r0,2 -> r1=0x00000002. Then lui r0,3 -> r0=0x00030000, which must not be suppressed.
- add r2,r0,r1 -> r2=0x00030002. Then sw r2,6(r1) -> dm.mm[2]=0x00030002.
- lw r3,2(r1) -> r3=0x00000001, read from dm.mm[1]. Then sra r4,r0,2 -> r4=0x0000C000.
- Branches:
  - beq r0,r1,20 at 0x18 is not taken; PC goes to 0x1C.
  - beq r10,r11,16 at 0x1C is taken; PC becomes 0x2C.
  - j 0 at 0x2C sets PC=0, and the program loops.
- Sign and logic checks:
  - slt with r5=0xFFFFFFFF and r6=1 -> 1; sltu on the same operands -> 0.
  - ori r7,r0,0x8000 -> r7 = r0 | 0x00008000.
  - addiu with imm 0xFFFF -> rs-1.
- Reset mid-program: assert rst at any cycle -> PC=0 after that edge, with no register or DM write in that cycle. Execution restarts from mm[0].
